// File: rtl/sudoku_pkg.sv
// Shared state codes and move-field constants for the Sudoku move path.
// Imported by the entry block and the move controller.
package sudoku_pkg;

  typedef enum logic [2:0] {
    ESPERA_LINHA  = 3'b000,
    ESPERA_COLUNA = 3'b001,
    ESPERA_VALOR  = 3'b011,
    ESCRITA       = 3'b010,
    VITORIA       = 3'b100,
    ERRO          = 3'b110
  } estado_t;

  localparam logic [3:0] VALOR_NENHUM = 4'd0;
  localparam int         ENDERECO_W   = 7;

  // Fields are 1-based; the cell index is 0-based row-major.
  function automatic logic [ENDERECO_W-1:0] calc_endereco(
    input logic [3:0] l,
    input logic [3:0] c
  );
    logic [ENDERECO_W-1:0] wl;
    logic [ENDERECO_W-1:0] wc;
    wl = ENDERECO_W'(l) - 7'd1;
    wc = ENDERECO_W'(c) - 7'd1;
    return wl * 7'd9 + wc;
  endfunction

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector: one-cycle pulse when i_sinal goes 0 -> 1.
// Holding the input high yields a single pulse.
module detector_borda (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sinal,
  output logic o_borda
);

  logic r_ant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ant <= 1'b0;
    else        r_ant <= i_sinal;
  end

  assign o_borda = i_sinal & ~r_ant;

endmodule

// File: rtl/controle_jogada.sv
// Move controller: captures row/column/value, writes the move to board
// memory via req/ack, and reports error and victory states.
module controle_jogada
  import sudoku_pkg::*;
#(
  parameter int ERRO_CICLOS    = 50_000_000,
  parameter int TIMEOUT_CICLOS = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            entrada,
  input  logic                  enableLinha,
  input  logic                  enableColuna,
  input  logic                  enableValor,
  input  logic                  keyVoltar,
  input  logic                  escritaAck,
  input  logic                  escritaOk,
  input  logic                  tabuleiroCompleto,
  output logic [2:0]            estadoJogo,
  output logic [3:0]            linha,
  output logic [3:0]            coluna,
  output logic [3:0]            valor,
  output logic                  escritaReq,
  output logic [ENDERECO_W-1:0] endereco,
  output logic                  erro,
  output logic [7:0]            jogadas
);

  estado_t               r_estado;
  logic                  r_req;
  logic                  r_erro;
  logic [3:0]            r_linha;
  logic [3:0]            r_coluna;
  logic [3:0]            r_valor;
  logic [ENDERECO_W-1:0] r_end;
  logic [7:0]            r_jogadas;
  logic [31:0]           r_timer;

  logic w_en;
  logic w_borda;
  logic w_valido;
  logic w_cap_lin;
  logic w_cap_col;
  logic w_cap_val;
  logic w_volta_col;
  logic w_volta_val;
  logic w_ok;
  logic w_falha;
  logic w_tmo;
  logic w_erro_fim;
  logic w_invalido;
  logic w_limpa;
  logic w_conta;

  assign w_en = enableLinha | enableColuna | enableValor;

  detector_borda u_borda (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_sinal (w_en),
    .o_borda (w_borda)
  );

  // keyVoltar has priority over a strobe in the same cycle.
  assign w_valido    = w_borda & (entrada != VALOR_NENHUM);
  assign w_cap_lin   = (r_estado == ESPERA_LINHA) & w_valido & enableLinha;
  assign w_volta_col = (r_estado == ESPERA_COLUNA) & keyVoltar;
  assign w_cap_col   = (r_estado == ESPERA_COLUNA) & w_valido
                     & enableColuna & ~keyVoltar;
  assign w_volta_val = (r_estado == ESPERA_VALOR) & keyVoltar;
  assign w_cap_val   = (r_estado == ESPERA_VALOR) & w_valido
                     & enableValor & ~keyVoltar;

  assign w_ok       = (r_estado == ESCRITA) & escritaAck & escritaOk;
  assign w_falha    = (r_estado == ESCRITA) & escritaAck & ~escritaOk;
  assign w_tmo      = (r_estado == ESCRITA) & ~escritaAck
                    & (r_timer == 32'(TIMEOUT_CICLOS - 1));
  assign w_erro_fim = (r_estado == ERRO)
                    & (r_timer == 32'(ERRO_CICLOS - 1));
  assign w_invalido = (r_estado != ESPERA_LINHA) & (r_estado != ESPERA_COLUNA)
                    & (r_estado != ESPERA_VALOR) & (r_estado != ESCRITA)
                    & (r_estado != ERRO) & (r_estado != VITORIA);

  assign w_limpa = (w_ok & ~tabuleiroCompleto) | w_falha | w_tmo | w_invalido;
  assign w_conta = ((r_estado == ESCRITA) & ~(w_ok | w_falha | w_tmo))
                 | ((r_estado == ERRO) & ~w_erro_fim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= ESPERA_LINHA;
      r_req    <= 1'b0;
      r_erro   <= 1'b0;
    end else begin
      case (r_estado)
        ESPERA_LINHA: begin
          if (w_cap_lin) r_estado <= ESPERA_COLUNA;
        end
        ESPERA_COLUNA: begin
          if (w_volta_col)     r_estado <= ESPERA_LINHA;
          else if (w_cap_col)  r_estado <= ESPERA_VALOR;
        end
        ESPERA_VALOR: begin
          if (w_volta_val) begin
            r_estado <= ESPERA_COLUNA;
          end else if (w_cap_val) begin
            r_estado <= ESCRITA;
            r_req    <= 1'b1;
          end
        end
        ESCRITA: begin
          if (w_ok) begin
            r_req    <= 1'b0;
            r_estado <= tabuleiroCompleto ? VITORIA : ESPERA_LINHA;
          end else if (w_falha | w_tmo) begin
            r_req    <= 1'b0;
            r_erro   <= 1'b1;
            r_estado <= ERRO;
          end
        end
        ERRO: begin
          if (w_erro_fim) begin
            r_erro   <= 1'b0;
            r_estado <= ESPERA_LINHA;
          end
        end
        VITORIA: r_estado <= VITORIA;
        default: begin
          r_estado <= ESPERA_LINHA;
          r_req    <= 1'b0;
          r_erro   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_linha  <= VALOR_NENHUM;
      r_coluna <= VALOR_NENHUM;
      r_valor  <= VALOR_NENHUM;
      r_end    <= '0;
    end else if (w_limpa) begin
      r_linha  <= VALOR_NENHUM;
      r_coluna <= VALOR_NENHUM;
      r_valor  <= VALOR_NENHUM;
      r_end    <= '0;
    end else begin
      if (w_cap_lin)   r_linha  <= entrada;
      if (w_volta_col) r_linha  <= VALOR_NENHUM;
      if (w_cap_col)   r_coluna <= entrada;
      if (w_volta_val) r_coluna <= VALOR_NENHUM;
      if (w_cap_val) begin
        r_valor <= entrada;
        r_end   <= calc_endereco(r_linha, r_coluna);
      end
    end
  end

  // One timer serves both the ack timeout and the error hold time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_timer <= '0;
    else if (w_conta) r_timer <= r_timer + 32'd1;
    else              r_timer <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_jogadas <= 8'd0;
    else if (w_ok && r_jogadas != 8'hFF) r_jogadas <= r_jogadas + 8'd1;
  end

  assign estadoJogo = r_estado;
  assign linha      = r_linha;
  assign coluna     = r_coluna;
  assign valor      = r_valor;
  assign escritaReq = r_req;
  assign endereco   = r_end;
  assign erro       = r_erro;
  assign jogadas    = r_jogadas;

endmodule
